// File: rtl/deriv_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : deriv_pkg
//  Description : Shared types and default sizes for the derivative scheduler.
//                Holds the scheduler state encoding, default channel count and
//                sample width, and the channel-index type for the default
//                configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
package deriv_pkg;

    localparam int NCH_DEFAULT = 4;
    localparam int W_DEFAULT   = 8;

    // Scheduler states:
    //   IDLE  - wait for any request
    //   ISSUE - operands presented, ack/dp_enb pulsed
    //   WAIT  - datapath latency countdown
    //   OUT   - result held until the consumer accepts it
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    typedef logic [$clog2(NCH_DEFAULT)-1:0] ch_idx_t;

endpackage : deriv_pkg
`default_nettype wire

// File: rtl/deriv_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Interface   : deriv_scheduler_if
//  Description : Bundles the requester side, the shared-datapath side and the
//                result stream of the derivative scheduler.
//  Ports (signals):
//    req/din/ack                 - per-channel sample requests and consumption
//    dp_enb/dp_cur/dp_prev/dp_res - shared derivative datapath
//    out_valid/out_ready/out_ch/out_d - tagged result stream
//  Modports    : slave  - the scheduler
//                master - the environment (sources, datapath, consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface deriv_scheduler_if #(
    parameter int NCH = 4,
    parameter int W   = 8
);
    logic [NCH-1:0]          req;
    logic [NCH*W-1:0]        din;
    logic [NCH-1:0]          ack;
    logic                    dp_enb;
    logic [W-1:0]            dp_cur;
    logic [W-1:0]            dp_prev;
    logic [W-1:0]            dp_res;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(NCH)-1:0]  out_ch;
    logic [W-1:0]            out_d;

    modport slave (
        input  req, din, dp_res, out_ready,
        output ack, dp_enb, dp_cur, dp_prev, out_valid, out_ch, out_d
    );

    modport master (
        output req, din, dp_res, out_ready,
        input  ack, dp_enb, dp_cur, dp_prev, out_valid, out_ch, out_d
    );
endinterface : deriv_scheduler_if
`default_nettype wire

// File: rtl/deriv_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Grants the lowest requesting
//                index at or above ptr, wrapping to the lowest requester below
//                ptr when nothing at or above it is asking.
//  Ports       : req   in  NCH         request vector
//                ptr   in  clog2(NCH)  round-robin start position
//                grant out NCH         one-hot winner (zero if no request)
//                idx   out clog2(NCH)  winner index
//                any   out 1           at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] idx,
    output logic                   any
);
    localparam int IW = $clog2(NCH);

    logic [NCH-1:0] hi_mask;
    logic [NCH-1:0] masked;
    logic [NCH-1:0] pick;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        masked = req & hi_mask;
        // Requests at/above the pointer take priority; otherwise wrap around.
        pick  = (|masked) ? masked : req;
        grant = '0;
        idx   = '0;
        // Descending scan so the last hit is the lowest set bit.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

    assign any = |req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/deriv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : deriv_scheduler
//  Description : Time-shares one external derivative datapath among NCH
//                sample requesters. Round-robin arbitration, per-channel
//                previous-sample context, one operand pair per grant, and a
//                tagged valid/ready result output.
//  Ports       : clk    in  1   rising-edge clock
//                reset  in  1   asynchronous, active-low reset
//                bus    slave modport of deriv_scheduler_if
//                       (req/din/ack, dp_*, out_*)
//  Revision    : 1.0 - initial release
// ============================================================================
module deriv_scheduler
    import deriv_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int W   = W_DEFAULT,
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    deriv_scheduler_if.slave  bus
);
    localparam int IW = $clog2(NCH);
    localparam int CW = $clog2(LAT + 1);

    state_t          state;
    state_t          state_nxt;

    logic [IW-1:0]   rr_ptr;
    logic [NCH-1:0]  win_grant;
    logic [IW-1:0]   win_idx;
    logic            any_req;
    logic [W-1:0]    win_din;

    logic [CW-1:0]   lat_cnt;
    logic [IW-1:0]   cur_ch;
    logic [W-1:0]    cur_smp;
    logic [W-1:0]    prev_smp;
    logic [W-1:0]    res_q;

    logic [W-1:0]    prev [NCH];
    logic [NCH-1:0]  primed;

    rr_arbiter #(
        .NCH   (NCH)
    ) u_arb (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (any_req)
    );

    assign win_din = bus.din[win_idx*W +: W];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)           state_nxt = ISSUE;
            ISSUE:                          state_nxt = WAIT;
            WAIT:    if (lat_cnt == '0)     state_nxt = OUT;
            // out_valid is high throughout OUT, so ready alone completes it.
            OUT:     if (bus.out_ready)     state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        bus.ack       = '0;
        bus.dp_enb    = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ISSUE: begin
                bus.ack[cur_ch] = 1'b1;
                bus.dp_enb      = 1'b1;
            end
            OUT:     bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, context bank, latency counter and result register.
    // The winner and its operands are frozen on the arbitration edge so
    // later req/din movement cannot disturb the transaction in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            cur_ch   <= '0;
            cur_smp  <= '0;
            prev_smp <= '0;
            res_q    <= '0;
            lat_cnt  <= '0;
            primed   <= '0;
            for (int i = 0; i < NCH; i++) begin
                prev[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_ch   <= win_idx;
                        cur_smp  <= win_din;
                        // An unprimed channel pairs the sample with itself,
                        // so its first derivative comes out as zero.
                        prev_smp <= primed[win_idx] ? prev[win_idx] : win_din;
                    end
                end
                ISSUE: begin
                    prev[cur_ch]   <= cur_smp;
                    primed[cur_ch] <= 1'b1;
                    rr_ptr         <= (cur_ch == IW'(NCH - 1)) ? '0 : cur_ch + IW'(1);
                    lat_cnt        <= CW'(LAT - 1);
                end
                WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end else begin
                        res_q <= bus.dp_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dp_cur  = cur_smp;
    assign bus.dp_prev = prev_smp;
    assign bus.out_ch  = cur_ch;
    assign bus.out_d   = res_q;

endmodule : deriv_scheduler
`default_nettype wire

// File: tb/tb_deriv_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_deriv_scheduler
//  Description : Self-checking bench for deriv_scheduler. Two instances
//                (LAT=1 and LAT=3) each driven with an external datapath
//                emulation whose result is only correct in the single cycle
//                LAT clocks after dp_enb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deriv_scheduler;
    import deriv_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    deriv_scheduler_if #(.NCH(NCH), .W(W)) ifc  ();
    deriv_scheduler_if #(.NCH(NCH), .W(W)) ifc3 ();

    deriv_scheduler #(.NCH(NCH), .W(W), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    deriv_scheduler #(.NCH(NCH), .W(W), .LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc3.slave)
    );

    // Datapath emulation: the right difference appears only in the cycle
    // exactly LAT clocks after dp_enb; every other cycle shows its complement.
    logic [W-1:0] d1_s;
    logic         d1_v;
    always_ff @(posedge clk) begin
        d1_s <= ifc.dp_cur - ifc.dp_prev;
        d1_v <= ifc.dp_enb;
    end
    assign ifc.dp_res = d1_v ? d1_s : ~d1_s;

    logic [W-1:0] d3_s [3];
    logic [2:0]   d3_v;
    always_ff @(posedge clk) begin
        d3_s[0] <= ifc3.dp_cur - ifc3.dp_prev;
        d3_s[1] <= d3_s[0];
        d3_s[2] <= d3_s[1];
        d3_v    <= {d3_v[1:0], ifc3.dp_enb};
    end
    assign ifc3.dp_res = d3_v[2] ? d3_s[2] : ~d3_s[2];

    // Reference model state (LAT=1 instance)
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] prev_m   [NCH];
    logic         primed_m [NCH];
    int           ptr_m;
    logic [NCH-1:0] add_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            prev_m[i]   = '0;
            primed_m[i] = 1'b0;
        end
        ptr_m = 0;
    endtask

    // First requesting channel scanning upward from the pointer, wrapping.
    function automatic int model_winner(input logic [NCH-1:0] rq);
        for (int k = 0; k < NCH; k++) begin
            if (rq[(ptr_m + k) % NCH]) return (ptr_m + k) % NCH;
        end
        return 0;
    endfunction

    task automatic set_din(input int ch, input logic [W-1:0] v);
        ifc.din[ch*W +: W] = v;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        ifc.req  = '0;
        ifc3.req = '0;
        ifc.out_ready  = 1'b1;
        ifc3.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    // One full transaction on the LAT=1 instance. want_ch/want_d < 0 means
    // take the expected value from the model.
    task automatic txn(input logic [NCH-1:0] add, input int want_ch, input int want_d,
                       input int stall, input bit keep);
        int           exp_ch;
        int           n;
        logic [W-1:0] smp;
        logic [W-1:0] exp_prev;
        logic [W-1:0] exp_d;
        ch_idx_t      hold_ch;
        logic [W-1:0] hold_d;
        ifc.req  = ifc.req | add;
        exp_ch   = model_winner(ifc.req);
        smp      = ifc.din[exp_ch*W +: W];
        exp_prev = primed_m[exp_ch] ? prev_m[exp_ch] : smp;
        exp_d    = smp - exp_prev;
        ifc.out_ready = (stall == 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (ifc.ack == '0 && n < 10);
        chk("ack_latency", n, 1);
        chk("ack_onehot", 32'(ifc.ack), 32'(1 << exp_ch));
        chk("dp_enb", 32'(ifc.dp_enb), 1);
        chk("dp_cur", 32'(ifc.dp_cur), 32'(smp));
        chk("dp_prev", 32'(ifc.dp_prev), 32'(exp_prev));
        prev_m[exp_ch]   = smp;
        primed_m[exp_ch] = 1'b1;
        ptr_m            = (exp_ch + 1) % NCH;
        if (!keep) ifc.req[exp_ch] = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            chk("no_ack_in_flight", 32'(ifc.ack), 0);
        end while (!ifc.out_valid && n < 10);
        chk("valid_latency", n, LAT + 1);
        chk("out_ch", 32'(ifc.out_ch), (want_ch >= 0) ? want_ch : exp_ch);
        chk("out_d", 32'(ifc.out_d), (want_d >= 0) ? want_d : 32'(exp_d));
        hold_ch = ifc.out_ch;
        hold_d  = ifc.out_d;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(ifc.out_valid), 1);
            chk("stall_out_d", 32'(ifc.out_d), 32'(hold_d));
            chk("stall_out_ch", 32'(ifc.out_ch), 32'(hold_ch));
            chk("stall_no_ack", 32'(ifc.ack), 0);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handshake_done", 32'(ifc.out_valid), 0);
    endtask

    task automatic lat3_txn(input logic [W-1:0] smp, input int want_d);
        int n;
        int ack_at;
        ifc3.din[2*W +: W] = smp;
        ifc3.req = 4'b0100;
        n = 0;
        ack_at = -1;
        do begin
            @(posedge clk); #1; n++;
            if (ifc3.ack != '0) begin
                ack_at = n;
                chk("lat3_ack", 32'(ifc3.ack), 32'h4);
                chk("lat3_dp_enb", 32'(ifc3.dp_enb), 1);
                ifc3.req = '0;
            end
        end while (!ifc3.out_valid && n < 20);
        chk("lat3_ack_at", ack_at, 1);
        chk("lat3_valid_at", n, 5);
        chk("lat3_out_ch", 32'(ifc3.out_ch), 2);
        chk("lat3_out_d", 32'(ifc3.out_d), want_d);
        @(posedge clk); #1;
        chk("lat3_handshake", 32'(ifc3.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        ifc.req        = '0;
        ifc.din        = '0;
        ifc.out_ready  = 1'b1;
        ifc3.req       = '0;
        ifc3.din       = '0;
        ifc3.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        chk("rst_ack", 32'(ifc.ack), 0);
        chk("rst_dp_enb", 32'(ifc.dp_enb), 0);
        chk("rst_out_valid", 32'(ifc.out_valid), 0);
        chk("rst_out_ch", 32'(ifc.out_ch), 0);
        chk("rst_out_d", 32'(ifc.out_d), 0);
        chk("rst_dp_cur", 32'(ifc.dp_cur), 0);
        chk("rst_dp_prev", 32'(ifc.dp_prev), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single channel: 10, 13, 20 on ch1
        set_din(1, 8'd10); txn(4'b0010, 1, 0, 0, 1'b0);
        set_din(1, 8'd13); txn(4'b0010, 1, 3, 0, 1'b0);
        set_din(1, 8'd20); txn(4'b0010, 1, 7, 0, 1'b0);

        // All-ones rotation with constant samples
        do_reset();
        set_din(0, 8'd5); set_din(1, 8'd9); set_din(2, 8'd2); set_din(3, 8'd7);
        for (int k = 0; k < 8; k++) begin
            txn(4'hF, k % 4, 0, 0, 1'b1);
        end
        ifc.req = '0;

        // Wraparound arithmetic
        set_din(0, 8'hFF); txn(4'b0001, 0, -1, 0, 1'b0);
        set_din(0, 8'h00); txn(4'b0001, 0, 8'h01, 0, 1'b0);
        set_din(2, 8'h80); txn(4'b0100, 2, -1, 0, 1'b0);
        set_din(2, 8'h7F); txn(4'b0100, 2, 8'hFF, 0, 1'b0);

        // Backpressure with ch3 still requesting
        set_din(3, 8'h33); txn(4'b1000, 3, -1, 5, 1'b1);
        ifc.req = '0;

        // Randomized traffic: requests persist until granted
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!ifc.req[c]) set_din(c, W'($urandom));
            end
            add_r = NCH'($urandom_range(0, (1 << NCH) - 1));
            if ((ifc.req | add_r) == '0) add_r = NCH'(1) << $urandom_range(0, NCH - 1);
            txn(add_r, -1, -1, int'($urandom_range(0, 2)), 1'b0);
        end
        ifc.req = '0;

        // Reset in WAIT after ch0 has been primed with 50
        set_din(0, 8'd50); txn(4'b0001, 0, -1, 0, 1'b0);
        set_din(0, 8'd55);
        ifc.req[0] = 1'b1;
        @(posedge clk); #1;
        chk("mid_ack", 32'(ifc.ack), 1);
        ifc.req = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ifc.ack), 0);
        chk("mid_rst_dp_enb", 32'(ifc.dp_enb), 0);
        chk("mid_rst_valid", 32'(ifc.out_valid), 0);
        chk("mid_rst_out_ch", 32'(ifc.out_ch), 0);
        chk("mid_rst_out_d", 32'(ifc.out_d), 0);
        chk("mid_rst_dp_cur", 32'(ifc.dp_cur), 0);
        chk("mid_rst_dp_prev", 32'(ifc.dp_prev), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_ack", 32'(ifc.ack), 0);
            chk("post_rst_no_valid", 32'(ifc.out_valid), 0);
        end
        set_din(0, 8'd60); txn(4'b0001, 0, 0, 0, 1'b0);

        // LAT=3 instance
        lat3_txn(8'd10, 0);
        lat3_txn(8'd25, 15);
        lat3_txn(8'd20, 8'hFB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_deriv_scheduler
`default_nettype wire

// File: doc/deriv_scheduler.md
# deriv_scheduler

Shares one derivative datapath among `NCH` sample requesters. The block round-robin arbitrates between requesters, keeps each channel's previous sample as context, and issues one operand pair per grant to the shared datapath. It then returns the tagged result on a valid/ready output. It sits between the per-channel sample sources and the single derivative unit, and replaces one derivative instance per channel.

## Interface
- `NCH`, 4, number of requesting channels (2..8)
- `W`, 8, sample and result width
- `LAT`, 1, datapath latency in cycles from `dp_enb` to a valid `dp_res` (1..4)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low; one clock domain
- `req`  in  NCH  per-channel sample request, level; held until the matching `ack`
- `din`  in  NCH*W  per-channel samples; channel i occupies bits [i*W +: W]
- `ack`  out  NCH  one-hot, one-cycle pulse; the sample is consumed
- `dp_enb`  out  1  one-cycle strobe to the shared datapath
- `dp_cur`  out  W  current sample
- `dp_prev`  out  W  stored previous sample for the granted channel
- `dp_res`  in  W  datapath result (dp_cur − dp_prev, mod 2^W)
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `out_ch`  out  clog2(NCH)  channel of the result
- `out_d`  out  W  derivative result

## Operation
- States:
  - IDLE: wait for any `req`.
  - ISSUE: latch the sample, pulse `ack` and `dp_enb`.
  - WAIT: count down `LAT`.
  - OUT: hold the result until the handshake completes.
- IDLE → ISSUE when `req` ≠ 0. The winner is the lowest index at or above `rr_ptr`, wrapping modulo NCH.
- ISSUE → WAIT always.
- WAIT → OUT when the counter reaches 0, capturing `dp_res` into `out_d`.
- OUT → IDLE when `out_valid && out_ready`.
- After a grant to channel i, `rr_ptr` becomes (i+1) mod NCH. A channel that requests continuously therefore cannot starve the others.
- Context per channel:
  - `prev[i]` is W bits and `primed[i]` is 1 bit.
  - In ISSUE, `prev[i]` ← `din[i]` and `primed[i]` ← 1.
  - `dp_prev` = `prev[i]` if primed, else `din[i]`, so the first derivative of any channel is 0.
- Arithmetic is two's-complement wrap. 0x00 − 0xFF = 0x01 and 0x7F − 0x80 = 0xFF. No saturation.
- `dp_cur`, `dp_prev` and `out_ch` stay stable from ISSUE until OUT exits.
- `req` changes after the arbitration cycle have no effect on the transaction in flight.

## Timing
- Reset values: state = IDLE; `rr_ptr` = 0; `ack`, `dp_enb`, `out_valid` = 0; `out_ch`, `out_d`, `dp_cur`, `dp_prev` = 0; all `prev` = 0; all `primed` = 0.
- Cycle 0: IDLE sees `req`.
- Cycle 1: ISSUE, with `ack[i]` = 1 and `dp_enb` = 1.
- Cycles 2..1+LAT: WAIT.
- Cycle 2+LAT: `out_valid` = 1.
- Minimum request-to-valid latency is LAT+2 cycles. Maximum throughput is one result per LAT+3 cycles when `out_ready` is held high.
- `out_valid` stays high while `out_ready` = 0. `out_d` and `out_ch` must not change during the stall.
- When `req` is all-ones, grants rotate 0,1,2,3,0,… with no repeats.
- Reset asserted mid-transaction returns to IDLE within the same cycle (asynchronous). The in-flight result is dropped, context and primed flags clear, and no `ack` is issued after release until a fresh arbitration.
- `ack` is never asserted in a cycle where `dp_enb` is low.

## Structure
- Package `deriv_pkg`:
  - state enum {IDLE, ISSUE, WAIT, OUT}
  - default `W` and `NCH` constants
  - a `ch_idx_t` typedef of width clog2(NCH)
- Sub-module `rr_arbiter`: combinational find-first-from-pointer over `req` plus the registered `rr_ptr`. It outputs a one-hot grant and the index.
- Top level: FSM, latency counter, context register bank, output register. The shared derivative datapath stays external.

## Test plan
- Reset then single channel: ch1 issues 10, 13, 20, with `out_ready` = 1 and LAT = 1.
  - Required `out_d`: 0, 3, 7, all with `out_ch` = 1.
  - `out_valid` rises 3 cycles after each `req`.
- All-ones `req`, constant samples ch0 = 5, ch1 = 9, ch2 = 2, ch3 = 7 over 8 grants.
  - `out_ch` sequence is 0,1,2,3,0,1,2,3.
  - First four `out_d` = 0; the next four = 0.
- Wrap: ch0 issues 0xFF then 0x00, giving `out_d` = 0x01. Ch2 issues 0x80 then 0x7F, giving `out_d` = 0xFF.
- Backpressure: hold `out_ready` = 0 for 5 cycles with ch3 requesting.
  - `out_valid`, `out_d` and `out_ch` stay stable.
  - No second `ack` occurs until the handshake completes.
- Mid-transaction reset, asserted in WAIT for ch0 after a prior sample of 50.
  - Outputs are 0 immediately.
  - After release, a sample of 60 gives `out_d` = 0, because the channel is unprimed again.
- LAT = 3 build: `dp_res` is captured exactly 3 cycles after `dp_enb`, and `out_valid` rises at cycle 5 after `req`.
